stego_extract_ctrl: RTL and testbench
=====================================

# stego_extract_ctrl

Sequencer that extracts a hidden text message from the image block RAM. It reads one LSB per RAM byte, assembles bits MSB-first into ASCII characters, and translates each character into the 6-bit seven-segment character code. It writes each code into the downstream character buffer that feeds the scrolling display. It sits between the start button logic and the BRAM/character buffer, and owns the BRAM port during extraction.

## Interface
- ADDR_W, 12, BRAM address width.
- START_ADDR, 0, first BRAM address holding a message bit.
- MAX_CHARS, 128, maximum characters extracted; power of two, at most 256.
- BRAM_LATENCY, 1, BRAM read latency in cycles; legal values 1 or 2.

- CLK100MHZ  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins extraction (accepted in IDLE or DONE only).
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  8  BRAM read data; only bit 0 is used.
- char_we  out  1  one-cycle write strobe to the character buffer.
- char_addr  out  log2(MAX_CHARS)  character index being written.
- char_code  out  6  display code: 0-9 digits, 10-35 letters, 36 blank.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE, until the next accepted start or Reset.
- msg_len  out  log2(MAX_CHARS)+1  characters written in the last extraction.
- overflow  out  1  extraction ended without a terminator.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE -> RUN on start.
  - On entry, clear the bit counter, char index, msg_len and overflow.
  - On entry, load bram_addr with START_ADDR.
- RUN behaviour:
  - bram_en=1 every cycle and bram_addr increments by 1 per cycle.
  - A valid-pipeline shift register of depth BRAM_LATENCY marks the cycles in which bram_dout is sampled.
- Assembly: the first sampled bit becomes bit 7 of the character; after 8 samples the byte is complete.
- Decode of a complete byte b:
  - 0x00 or 0x20 -> 36.
  - 0x30-0x39 -> b-48.
  - 0x41-0x5A -> b-55.
  - 0x61-0x7A -> b-87.
  - Any other value -> 36.
- Write rules:
  - Every complete byte is written (char_we) except a terminating NUL.
  - msg_len increments on each write.
- Termination:
  - A NUL at char index >= 1 ends RUN; it is not written, and RUN -> DRAIN.
  - A NUL at index 0 is written as blank (36) and extraction continues.
- Limits:
  - If MAX_CHARS characters have been written, RUN -> DRAIN with overflow=1.
  - If bram_addr would wrap past 2^ADDR_W-1, RUN -> DRAIN with overflow=1; a partial byte is discarded.
- DRAIN:
  - bram_en=0; lasts BRAM_LATENCY cycles.
  - In-flight read data is discarded.
  - DRAIN -> DONE.
- start in RUN or DRAIN is ignored.
- start in DONE restarts from START_ADDR and char index 0. The buffer is not cleared; stale entries beyond the new msg_len remain.

## Timing
- Reset values:
  - state IDLE.
  - bram_en=0, bram_addr=START_ADDR.
  - char_we=0, char_addr=0, char_code=36.
  - busy=0, done=0, msg_len=0, overflow=0.
- Reset asserted mid-operation forces reset values immediately (asynchronous). No further char_we occurs, and no partial state survives.
- Cycle numbering:
  - start sampled high at cycle 0.
  - RUN from cycle 1; address START_ADDR+k is presented at cycle 1+k.
  - The bit for address START_ADDR+k is sampled at cycle 1+k+BRAM_LATENCY.
- Character n completes at cycle 8+8n+BRAM_LATENCY.
- char_we for character n is registered and high at cycle 9+8n+BRAM_LATENCY. char_addr=n and char_code are valid in the same cycle.
- The state transition out of RUN occurs on the cycle after the terminating byte completes.
- done rises BRAM_LATENCY+1 cycles after that byte completes; busy falls in the same cycle.
- msg_len and overflow are stable whenever done=1.
- start coincident with a terminating byte in RUN is ignored.

## Test plan
- BRAM LSBs encode 'H','I',0x00 at START_ADDR=0, BRAM_LATENCY=1 -> writes (0,17) at cycle 10 and (1,18) at cycle 18; done=1, msg_len=2, overflow=0.
- Bytes 'a','9',' ','!',0x00 -> codes 10, 9, 36, 36 at addresses 0-3; msg_len=4.
- Bytes 0x00,'A',0x00 -> writes (0,36) and (1,10); msg_len=2; a third write never occurs.
- MAX_CHARS=4, no NUL in RAM -> exactly 4 writes; overflow=1, msg_len=4; bram_en low from DRAIN onward.
- Reset pulled low at cycle 20 of RUN -> all outputs at reset values in that cycle. A new start then writes char 0 again at cycle 9+BRAM_LATENCY after start.
- start pulsed repeatedly during RUN -> no restart, identical write sequence. Repeat with BRAM_LATENCY=2 -> all writes shifted by one cycle.

Source files
------------

// File: rtl/stego_extract_ctrl_if.sv
// Bus bundle between the message-extraction sequencer, the image BRAM read
// port, the character buffer write port and the start button logic.
interface stego_extract_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int CA_W   = 7
);
    logic              start;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_dout;
    logic              char_we;
    logic [CA_W-1:0]   char_addr;
    logic [5:0]        char_code;
    logic              busy;
    logic              done;
    logic [CA_W:0]     msg_len;
    logic              overflow;

    modport master (
        input  start, bram_dout,
        output bram_en, bram_addr, char_we, char_addr, char_code,
               busy, done, msg_len, overflow
    );

    modport slave (
        output start, bram_dout,
        input  bram_en, bram_addr, char_we, char_addr, char_code,
               busy, done, msg_len, overflow
    );
endinterface

// File: rtl/stego_extract_ctrl.sv
// Pulls one LSB per BRAM byte, packs them MSB-first into ASCII, converts each
// character to a seven-segment code and writes it to the character buffer.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RUN   | streaming BRAM reads, assembling and writing characters
// DRAIN | BRAM disabled while in-flight reads fall away
// DONE  | msg_len/overflow valid, waiting for a restart
module stego_extract_ctrl #(
    parameter int ADDR_W       = 12,
    parameter int START_ADDR   = 0,
    parameter int MAX_CHARS    = 128,
    parameter int BRAM_LATENCY = 1
) (
    input  logic                 CLK100MHZ,
    input  logic                 Reset,
    stego_extract_ctrl_if.master bus
);
    localparam int         CA_W       = $clog2(MAX_CHARS);
    localparam logic [5:0] CODE_BLANK = 6'd36;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [BRAM_LATENCY-1:0] vld_pipe;
    logic [2:0]              bit_cnt;
    logic [6:0]              shift;
    logic [1:0]              drain_cnt;
    logic [ADDR_W-1:0]       bram_addr;
    logic [CA_W:0]           msg_len;   // doubles as the next character index
    logic                    overflow;
    logic                    char_we;
    logic [CA_W-1:0]         char_addr;
    logic [5:0]              char_code;

    logic       start_ok, sample, byte_done, is_term, do_write;
    logic       hit_max, at_top, stop_ovf;
    logic [7:0] byte_val;
    logic       unused_dout;

    assign unused_dout = ^bus.bram_dout[7:1];

    function automatic logic [5:0] decode(input logic [7:0] b);
        logic [5:0] c;
        c = CODE_BLANK;
        if (b >= 8'h30 && b <= 8'h39)      c = 6'(b - 8'd48);
        else if (b >= 8'h41 && b <= 8'h5A) c = 6'(b - 8'd55);
        else if (b >= 8'h61 && b <= 8'h7A) c = 6'(b - 8'd87);
        return c;
    endfunction

    // Per-cycle qualifiers: sampling, byte completion, termination and limits.
    always_comb begin
        start_ok  = bus.start && (state == IDLE || state == DONE);
        sample    = (state == RUN) && vld_pipe[BRAM_LATENCY-1];
        byte_val  = {shift, bus.bram_dout[0]};
        byte_done = sample && (bit_cnt == 3'd7);
        // A NUL in slot 0 is treated as a blank, not an end marker.
        is_term   = byte_done && (byte_val == 8'h00) && (msg_len != '0);
        do_write  = byte_done && !is_term;
        hit_max   = do_write && (msg_len == (CA_W+1)'(MAX_CHARS - 1));
        at_top    = (state == RUN) && (bram_addr == {ADDR_W{1'b1}});
        stop_ovf  = !is_term && (hit_max || at_top);
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nx = RUN;
            RUN:        if (is_term || stop_ovf) state_nx = DRAIN;
            DRAIN:      if (drain_cnt == 2'd0) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Read address, read-valid pipeline, bit assembly and drain timer.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            bram_addr <= ADDR_W'(START_ADDR);
            vld_pipe  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            drain_cnt <= '0;
        end else begin
            vld_pipe[0] <= (state == RUN);
            for (int i = 1; i < BRAM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (start_ok) begin
                bram_addr <= ADDR_W'(START_ADDR);
                bit_cnt   <= '0;
                shift     <= '0;
            end else if (state == RUN) begin
                // Hold at the top address; the wrap check ends the run instead.
                if (!at_top) bram_addr <= bram_addr + 1'b1;
                if (sample) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shift   <= {shift[5:0], bus.bram_dout[0]};
                end
            end
            if (state == RUN && state_nx == DRAIN)
                drain_cnt <= 2'(BRAM_LATENCY - 1);
            else if (state == DRAIN && drain_cnt != 2'd0)
                drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // Character buffer write port and extraction results.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            char_we   <= 1'b0;
            char_addr <= '0;
            char_code <= CODE_BLANK;
            msg_len   <= '0;
            overflow  <= 1'b0;
        end else begin
            char_we <= do_write;
            if (start_ok) begin
                msg_len  <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_write) begin
                    char_addr <= msg_len[CA_W-1:0];
                    char_code <= decode(byte_val);
                    msg_len   <= msg_len + 1'b1;
                end
                if (stop_ovf) overflow <= 1'b1;
            end
        end
    end

    assign bus.bram_en   = (state == RUN);
    assign bus.bram_addr = bram_addr;
    assign bus.char_we   = char_we;
    assign bus.char_addr = char_addr;
    assign bus.char_code = char_code;
    assign bus.busy      = (state == RUN) || (state == DRAIN);
    assign bus.done      = (state == DONE);
    assign bus.msg_len   = msg_len;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_stego_extract_ctrl.sv
`timescale 1ns/1ps
module tb_stego_extract_ctrl;
    localparam int NI = 4;

    logic CLK100MHZ = 1'b0;
    logic Reset     = 1'b1;
    logic start     = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // u0: L=1 MAX=128, u1: L=2 MAX=128, u2: L=1 MAX=4, u3: L=2 ADDR_W=6
    stego_extract_ctrl_if #(.ADDR_W(12), .CA_W(7)) if0 ();
    stego_extract_ctrl_if #(.ADDR_W(12), .CA_W(7)) if1 ();
    stego_extract_ctrl_if #(.ADDR_W(12), .CA_W(2)) if2 ();
    stego_extract_ctrl_if #(.ADDR_W(6),  .CA_W(7)) if3 ();

    assign if0.start = start;
    assign if1.start = start;
    assign if2.start = start;
    assign if3.start = start;

    stego_extract_ctrl #(.ADDR_W(12), .START_ADDR(0), .MAX_CHARS(128), .BRAM_LATENCY(1))
        u0 (.CLK100MHZ(CLK100MHZ), .Reset(Reset), .bus(if0.master));
    stego_extract_ctrl #(.ADDR_W(12), .START_ADDR(0), .MAX_CHARS(128), .BRAM_LATENCY(2))
        u1 (.CLK100MHZ(CLK100MHZ), .Reset(Reset), .bus(if1.master));
    stego_extract_ctrl #(.ADDR_W(12), .START_ADDR(0), .MAX_CHARS(4), .BRAM_LATENCY(1))
        u2 (.CLK100MHZ(CLK100MHZ), .Reset(Reset), .bus(if2.master));
    stego_extract_ctrl #(.ADDR_W(6), .START_ADDR(0), .MAX_CHARS(128), .BRAM_LATENCY(2))
        u3 (.CLK100MHZ(CLK100MHZ), .Reset(Reset), .bus(if3.master));

    function automatic int lat_of(input int i); return (i == 1 || i == 3) ? 2 : 1; endfunction
    function automatic int max_of(input int i); return (i == 2) ? 4 : 128; endfunction
    function automatic int aw_of(input int i);  return (i == 3) ? 6 : 12; endfunction

    // Message bytes; bit k of the image is bit (7 - k%8) of byte k/8.
    logic [7:0] mem [512];
    function automatic logic mem_bit(input int a);
        return mem[a / 8][7 - (a % 8)];
    endfunction

    // BRAM models with random upper data bits.
    logic [7:0] p1, p3;
    always @(posedge CLK100MHZ)
        if (if0.bram_en) if0.bram_dout <= {7'($urandom), mem_bit(int'(if0.bram_addr))};
    always @(posedge CLK100MHZ) begin
        if (if1.bram_en) p1 <= {7'($urandom), mem_bit(int'(if1.bram_addr))};
        if1.bram_dout <= p1;
    end
    always @(posedge CLK100MHZ)
        if (if2.bram_en) if2.bram_dout <= {7'($urandom), mem_bit(int'(if2.bram_addr))};
    always @(posedge CLK100MHZ) begin
        if (if3.bram_en) p3 <= {7'($urandom), mem_bit(int'(if3.bram_addr))};
        if3.bram_dout <= p3;
    end

    typedef struct { int inst; int cyc; int addr; int code; } wr_t;
    typedef struct { int en; int baddr; int we; int caddr; int code;
                     int busy; int done; int len; int ovf; } snap_t;
    typedef struct { logic [7:0] ch; int code; } vec_t;

    wr_t act_q[$];
    wr_t exp_q[$];
    int  exp_len [NI];
    int  exp_ovf [NI];
    int  exp_done[NI];
    int  done_act[NI];
    int  cyc = 0;
    int  s0 = 0;
    bit  armed = 1'b0;
    int  n_pass = 0;
    int  n_tot = 0;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic snap_t snap(input int i);
        snap_t s;
        case (i)
            0: s = '{int'(if0.bram_en), int'(if0.bram_addr), int'(if0.char_we), int'(if0.char_addr),
                     int'(if0.char_code), int'(if0.busy), int'(if0.done), int'(if0.msg_len), int'(if0.overflow)};
            1: s = '{int'(if1.bram_en), int'(if1.bram_addr), int'(if1.char_we), int'(if1.char_addr),
                     int'(if1.char_code), int'(if1.busy), int'(if1.done), int'(if1.msg_len), int'(if1.overflow)};
            2: s = '{int'(if2.bram_en), int'(if2.bram_addr), int'(if2.char_we), int'(if2.char_addr),
                     int'(if2.char_code), int'(if2.busy), int'(if2.done), int'(if2.msg_len), int'(if2.overflow)};
            default: s = '{int'(if3.bram_en), int'(if3.bram_addr), int'(if3.char_we), int'(if3.char_addr),
                     int'(if3.char_code), int'(if3.busy), int'(if3.done), int'(if3.msg_len), int'(if3.overflow)};
        endcase
        return s;
    endfunction

    task automatic rec(input int i, input logic we, input int a, input int c, input logic dn);
        if (we) act_q.push_back('{i, cyc - s0, a, c});
        if (dn && done_act[i] < 0 && cyc > s0) done_act[i] = cyc - s0;
    endtask

    always @(negedge CLK100MHZ) begin
        if (armed) begin
            rec(0, if0.char_we, int'(if0.char_addr), int'(if0.char_code), if0.done);
            rec(1, if1.char_we, int'(if1.char_addr), int'(if1.char_code), if1.done);
            rec(2, if2.char_we, int'(if2.char_addr), int'(if2.char_code), if2.done);
            rec(3, if3.char_we, int'(if3.char_addr), int'(if3.char_code), if3.done);
        end
    end

    // Display glyph table: position in the string is the code.
    function automatic int code_of(input logic [7:0] b);
        string glyphs;
        glyphs = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        for (int i = 0; i < 36; i++) begin
            if (int'(glyphs[i]) == int'(b)) return i;
            if (i >= 10 && int'(glyphs[i]) + 32 == int'(b)) return i;
        end
        return 36;
    endfunction

    // Reference: walk the message bytes, deciding each character's fate and
    // the cycle it lands on from the documented timeline.
    task automatic model(input int i);
        int lat, mx, top, n, len, ovf, endc, comp;
        lat = lat_of(i); mx = max_of(i); top = 1 << aw_of(i);
        n = 0; len = 0; ovf = 0; endc = 0;
        forever begin
            comp = 8 + 8 * n + lat;
            if (comp > top) begin ovf = 1; endc = top; break; end
            if (mem[n] == 8'h00 && n >= 1) begin endc = comp; break; end
            exp_q.push_back('{i, comp + 1, n, code_of(mem[n])});
            len++;
            if (len == mx) begin ovf = 1; endc = comp; break; end
            n++;
        end
        exp_len[i] = len; exp_ovf[i] = ovf; exp_done[i] = endc + lat + 1;
    endtask

    task automatic set_msg(input logic [7:0] m [8], input int n);
        for (int j = 0; j < 512; j++)
            mem[j] = (j < n) ? m[j] : 8'($urandom_range(1, 255));
    endtask

    task automatic run_all(input bit hold_start);
        int mx_done, mn_done;
        wr_t e[$];
        wr_t a[$];
        snap_t s;
        exp_q.delete(); act_q.delete();
        mx_done = 0; mn_done = 1 << 30;
        for (int i = 0; i < NI; i++) begin
            model(i);
            done_act[i] = -1;
            if (exp_done[i] > mx_done) mx_done = exp_done[i];
            if (exp_done[i] < mn_done) mn_done = exp_done[i];
        end
        @(posedge CLK100MHZ); #1;
        start = 1'b1; s0 = cyc; armed = 1'b1;
        for (int c = 1; c <= mx_done + 4; c++) begin
            @(posedge CLK100MHZ); #1;
            start = hold_start && (c < mn_done);
        end
        start = 1'b0; armed = 1'b0;
        for (int i = 0; i < NI; i++) begin
            e = exp_q.find with (item.inst == i);
            a = act_q.find with (item.inst == i);
            chk($sformatf("u%0d write count", i), a.size(), e.size());
            for (int k = 0; k < e.size() && k < a.size(); k++) begin
                chk($sformatf("u%0d w%0d cycle", i, k), a[k].cyc, e[k].cyc);
                chk($sformatf("u%0d w%0d addr", i, k), a[k].addr, e[k].addr);
                chk($sformatf("u%0d w%0d code", i, k), a[k].code, e[k].code);
            end
            chk($sformatf("u%0d done cycle", i), done_act[i], exp_done[i]);
            s = snap(i);
            chk($sformatf("u%0d msg_len", i), s.len, exp_len[i]);
            chk($sformatf("u%0d overflow", i), s.ovf, exp_ovf[i]);
            chk($sformatf("u%0d done", i), s.done, 1);
            chk($sformatf("u%0d busy", i), s.busy, 0);
            chk($sformatf("u%0d bram_en", i), s.en, 0);
        end
    endtask

    task automatic chk_wr(input int i, input int k, input int c, input int ad, input int code);
        wr_t q[$];
        q = act_q.find with (item.inst == i);
        if (k >= q.size()) chk($sformatf("u%0d w%0d present", i, k), q.size(), k + 1);
        else begin
            chk($sformatf("u%0d hand w%0d cycle", i, k), q[k].cyc, c);
            chk($sformatf("u%0d hand w%0d addr", i, k), q[k].addr, ad);
            chk($sformatf("u%0d hand w%0d code", i, k), q[k].code, code);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        snap_t s;
        for (int i = 0; i < NI; i++) begin
            s = snap(i);
            chk($sformatf("%s u%0d bram_en", tag, i), s.en, 0);
            chk($sformatf("%s u%0d bram_addr", tag, i), s.baddr, 0);
            chk($sformatf("%s u%0d char_we", tag, i), s.we, 0);
            chk($sformatf("%s u%0d char_addr", tag, i), s.caddr, 0);
            chk($sformatf("%s u%0d char_code", tag, i), s.code, 36);
            chk($sformatf("%s u%0d busy", tag, i), s.busy, 0);
            chk($sformatf("%s u%0d done", tag, i), s.done, 0);
            chk($sformatf("%s u%0d msg_len", tag, i), s.len, 0);
            chk($sformatf("%s u%0d overflow", tag, i), s.ovf, 0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       vtab [14];
        logic [7:0] m [8];
        snap_t      s;
        wr_t        q[$];
        int         r;

        vtab = '{'{8'h30, 0},  '{8'h39, 9},  '{8'h41, 10}, '{8'h5A, 35},
                 '{8'h61, 10}, '{8'h7A, 35}, '{8'h20, 36}, '{8'h40, 36},
                 '{8'h5B, 36}, '{8'h60, 36}, '{8'h7B, 36}, '{8'h2F, 36},
                 '{8'h3A, 36}, '{8'h00, 36}};

        #1 Reset = 1'b0;
        #2 chk_reset_vals("por");
        repeat (2) @(posedge CLK100MHZ);
        #1 Reset = 1'b1;

        // "HI" then NUL
        m = '{8'h48, 8'h49, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_msg(m, 3);
        run_all(1'b0);
        chk_wr(0, 0, 10, 0, 17);
        chk_wr(0, 1, 18, 1, 18);
        chk_wr(1, 0, 11, 0, 17);

        // Single-character decode table
        for (int v = 0; v < 14; v++) begin
            m = '{vtab[v].ch, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
            set_msg(m, 2);
            run_all(1'b0);
            chk_wr(0, 0, 10, 0, vtab[v].code);
        end

        // 'a','9',' ','!',NUL
        m = '{8'h61, 8'h39, 8'h20, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00};
        set_msg(m, 5);
        run_all(1'b0);
        chk_wr(0, 0, 10, 0, 10);
        chk_wr(0, 1, 18, 1, 9);
        chk_wr(0, 2, 26, 2, 36);
        chk_wr(0, 3, 34, 3, 36);
        s = snap(0);
        chk("hand a9 msg_len", s.len, 4);

        // Leading NUL is a blank, second NUL terminates
        m = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_msg(m, 3);
        run_all(1'b0);
        chk_wr(0, 0, 10, 0, 36);
        chk_wr(0, 1, 18, 1, 10);
        q = act_q.find with (item.inst == 0);
        chk("hand leading nul writes", q.size(), 2);

        // No terminator anywhere: MAX_CHARS and address wrap limits
        for (int j = 0; j < 512; j++) mem[j] = 8'($urandom_range(8'h41, 8'h5A));
        run_all(1'b0);
        q = act_q.find with (item.inst == 2);
        chk("hand max4 writes", q.size(), 4);
        s = snap(2);
        chk("hand max4 overflow", s.ovf, 1);
        chk("hand max4 msg_len", s.len, 4);
        s = snap(3);
        chk("hand wrap overflow", s.ovf, 1);
        chk("hand wrap msg_len", s.len, 7);

        // start held during RUN/DRAIN, including on the terminating byte
        m = '{8'h48, 8'h49, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_msg(m, 3);
        run_all(1'b1);
        chk_wr(0, 0, 10, 0, 17);
        chk_wr(1, 1, 19, 1, 18);

        // Reset asserted at cycle 20 of a run
        m = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h00, 8'h00, 8'h00};
        set_msg(m, 6);
        @(posedge CLK100MHZ); #1 start = 1'b1;
        @(posedge CLK100MHZ); #1 start = 1'b0;
        repeat (19) @(posedge CLK100MHZ);
        #1 Reset = 1'b0;
        #1 chk_reset_vals("midrun");
        repeat (3) begin
            @(negedge CLK100MHZ);
            s = snap(0);
            chk("reset hold char_we", s.we, 0);
        end
        @(posedge CLK100MHZ); #1 Reset = 1'b1;
        run_all(1'b0);
        chk_wr(0, 0, 10, 0, 17);
        chk_wr(1, 0, 11, 0, 17);

        // Randomized messages against the reference model
        repeat (6) begin
            for (int j = 0; j < 512; j++) begin
                r = $urandom_range(0, 5);
                if (r == 0)      mem[j] = 8'h00;
                else if (r == 1) mem[j] = 8'($urandom);
                else             mem[j] = 8'($urandom_range(32, 126));
            end
            run_all(1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
